// File: rtl/pulse_stretch_multi.sv
// Multi-channel pulse stretcher: each rising input edge produces a pulse of hold_len cycles.
// Optional input synchroniser is enabled with the PULSE_STRETCH_SYNC_EN macro.
module pulse_stretch_multi #(
    parameter int unsigned NCH   = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NCH-1:0]   sig_in,
    input  logic [CNT_W-1:0] hold_len,
    input  logic             retrig,
    input  logic             enable,
    input  logic             clr_missed,
    output logic [NCH-1:0]   sig_out,
    output logic [NCH-1:0]   missed,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    logic [NCH-1:0]   src;
    logic [NCH-1:0]   prev_q;
    logic [NCH-1:0]   trig;
    logic [CNT_W-1:0] load_val;

    state_e           state_q [NCH];
    state_e           state_d [NCH];
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_d   [NCH];
    logic [NCH-1:0]   out_q, out_d;
    logic [NCH-1:0]   missed_q, missed_d;
    logic             busy_q;

`ifdef PULSE_STRETCH_SYNC_EN
    logic [NCH-1:0] sync1_q, sync2_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sig_in;
            sync2_q <= sync1_q;
        end
    end

    assign src = sync2_q;
`else
    assign src = sig_in;
`endif

    assign trig = src & ~prev_q;

    // hold_len of 0 is treated as a 1-cycle pulse, so both load a count of 0
    assign load_val = (hold_len == '0) ? '0 : hold_len - CNT_W'(1);

    always_comb begin
        missed_d = missed_q & ~{NCH{clr_missed}};
        out_d    = '0;
        for (int unsigned i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (state_q[i] == IDLE) begin
                if (trig[i] && enable) begin
                    state_d[i] = HOLD;
                    cnt_d[i]   = load_val;
                end
            end else begin
                if (trig[i] && enable && retrig) begin
                    cnt_d[i] = load_val;
                end else begin
                    // Set after the clear so a same-cycle miss survives clr_missed
                    if (trig[i] && enable) begin
                        missed_d[i] = 1'b1;
                    end
                    if (cnt_q[i] == '0) begin
                        state_d[i] = IDLE;
                    end else begin
                        cnt_d[i] = cnt_q[i] - CNT_W'(1);
                    end
                end
            end
            out_d[i] = (state_d[i] == HOLD);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= IDLE;
                cnt_q[i]   <= '0;
            end
            prev_q   <= '0;
            out_q    <= '0;
            missed_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            prev_q   <= src;
            out_q    <= out_d;
            missed_q <= missed_d;
            busy_q   <= |out_d;
        end
    end

    assign sig_out = out_q;
    assign missed  = missed_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_pulse_stretch_multi.sv
// Scoreboard bench for pulse_stretch_multi: an end-time reference model queues expected outputs per cycle.
module tb_pulse_stretch_multi;

`ifdef PULSE_STRETCH_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] sig_in;
    logic [7:0] hold_len;
    logic       retrig;
    logic       enable;
    logic       clr_missed;
    logic [7:0] sig_out;
    logic [7:0] missed;
    logic       busy;

    always #5 clock = ~clock;

    pulse_stretch_multi #(.NCH(8), .CNT_W(8)) dut (
        .clock      (clock),
        .reset      (reset),
        .sig_in     (sig_in),
        .hold_len   (hold_len),
        .retrig     (retrig),
        .enable     (enable),
        .clr_missed (clr_missed),
        .sig_out    (sig_out),
        .missed     (missed),
        .busy       (busy)
    );

    typedef struct packed {
        logic [7:0] so;
        logic [7:0] ms;
        logic       b;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 1'b0;
    int   hi_cnt[8];

    // Reference model: each channel remembers the cycle at which its pulse ends
    int         cyc = 0;
    int         end_c[8];
    logic [7:0] m_out  = '0;
    logic [7:0] m_ms   = '0;
    logic [7:0] m_prev = '0;
    logic [7:0] m_s1   = '0;
    logic [7:0] m_s2   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        logic [7:0] src, trig, setm;
        int         len;
        exp_t       e;
        cyc++;
        if (reset) begin
            m_out = '0; m_ms = '0; m_prev = '0; m_s1 = '0; m_s2 = '0;
            for (int i = 0; i < 8; i++) end_c[i] = 0;
        end else begin
`ifdef PULSE_STRETCH_SYNC_EN
            src  = m_s2;
            m_s2 = m_s1;
            m_s1 = sig_in;
`else
            src = sig_in;
`endif
            trig   = src & ~m_prev;
            m_prev = src;
            setm   = '0;
            len    = (hold_len == 0) ? 1 : int'(hold_len);
            for (int i = 0; i < 8; i++) begin
                if (trig[i] && enable) begin
                    if (!m_out[i] || retrig) end_c[i] = cyc + len;
                    else setm[i] = 1'b1;
                end
                m_out[i] = (cyc < end_c[i]);
            end
            m_ms = (m_ms & ~{8{clr_missed}}) | setm;
        end
        e.so = m_out;
        e.ms = m_ms;
        e.b  = |m_out;
        sb.push_back(e);
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clr_hi();
        for (int i = 0; i < 8; i++) hi_cnt[i] = 0;
    endtask

    function automatic int hi_sum_except(input int ch);
        int s = 0;
        for (int i = 0; i < 8; i++) if (i != ch) s += hi_cnt[i];
        return s;
    endfunction

    initial begin
        exp_t e;
        while (!done) begin
            @(posedge clock);
            #1;
            if (done) break;
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = sb.pop_front();
                chk("sig_out", 32'(sig_out), 32'(e.so));
                chk("missed",  32'(missed),  32'(e.ms));
                chk("busy",    32'(busy),    32'(e.b));
                for (int i = 0; i < 8; i++) if (sig_out[i]) hi_cnt[i]++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; sig_in = '0; hold_len = 8'd20;
        retrig = 1'b0; enable = 1'b1; clr_missed = 1'b0;
        clr_hi();
        ticks(3);
        chk("reset_out",    32'(sig_out), 32'd0);
        chk("reset_missed", 32'(missed),  32'd0);
        chk("reset_busy",   32'(busy),    32'd0);
        reset = 1'b0;
        ticks(2);

        // Single 20-cycle pulse on ch0
        clr_hi();
        sig_in = 8'h01; tick();
        sig_in = 8'h00; ticks(25);
        chk("single_len", 32'(hi_cnt[0]), 32'd20);
        chk("single_others", 32'(hi_sum_except(0)), 32'd0);

        // Non-retriggerable miss on ch3, then clear, then clear racing a new miss
        clr_hi(); hold_len = 8'd10;
        sig_in = 8'h08; tick();
        sig_in = 8'h00; ticks(4);
        sig_in = 8'h08; tick();
        sig_in = 8'h00; ticks(14);
        chk("nonretrig_len", 32'(hi_cnt[3]), 32'd10);
        chk("nonretrig_missed", 32'(missed[3]), 32'd1);
        clr_missed = 1'b1; tick();
        clr_missed = 1'b0; tick();
        chk("missed_cleared", 32'(missed[3]), 32'd0);
        sig_in = 8'h08; tick();
        sig_in = 8'h00; ticks(2);
        sig_in = 8'h08; clr_missed = 1'b1; tick();
        sig_in = 8'h00; clr_missed = 1'b0; ticks(3 + SYNC_LAT);
        chk("clr_vs_set", 32'(missed[3]), 32'd1);
        ticks(12);
        clr_missed = 1'b1; tick();
        clr_missed = 1'b0; ticks(2);

        // Retrigger on ch5 at 0, 5, 9
        clr_hi(); retrig = 1'b1;
        sig_in = 8'h20; tick();
        sig_in = 8'h00; ticks(4);
        sig_in = 8'h20; tick();
        sig_in = 8'h00; ticks(3);
        sig_in = 8'h20; tick();
        sig_in = 8'h00; ticks(20);
        chk("retrig_len", 32'(hi_cnt[5]), 32'd19);
        chk("retrig_missed", 32'(missed), 32'd0);
        retrig = 1'b0;

        // Length boundaries and a long level
        clr_hi(); hold_len = 8'd0;
        sig_in = 8'h04; tick();
        sig_in = 8'h00; ticks(5);
        chk("len0", 32'(hi_cnt[2]), 32'd1);
        clr_hi(); hold_len = 8'd255;
        sig_in = 8'h40; tick();
        sig_in = 8'h00; ticks(260);
        chk("len255", 32'(hi_cnt[6]), 32'd255);
        clr_hi();
        sig_in = 8'h80; ticks(300);
        sig_in = 8'h00; ticks(5);
        chk("level_once", 32'(hi_cnt[7]), 32'd255);

        // Enable low blocks all triggers
        clr_hi(); hold_len = 8'd5; enable = 1'b0;
        sig_in = 8'hFF; tick();
        sig_in = 8'h00; ticks(5);
        enable = 1'b1; ticks(2);
        chk("enable_out", 32'(hi_sum_except(-1)), 32'd0);
        chk("enable_missed", 32'(missed), 32'd0);

        // Reset mid-pulse with input held high across release
        clr_hi(); hold_len = 8'd20;
        sig_in = 8'h02; ticks(4);
        reset = 1'b1; tick();
        chk("reset_abort", 32'(sig_out), 32'd0);
        tick();
        reset = 1'b0; ticks(25);
        sig_in = 8'h00; ticks(2);
        chk("reset_retrig", 32'(hi_cnt[1]), 32'(24 - SYNC_LAT));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            sig_in     = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 19) == 0) hold_len = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 49) == 0) retrig = 1'($urandom);
            enable     = ($urandom_range(0, 9) != 0);
            clr_missed = ($urandom_range(0, 19) == 0);
            reset      = ($urandom_range(0, 99) == 0);
            tick();
        end
        reset = 1'b0; sig_in = '0; clr_missed = 1'b0; enable = 1'b1;
        ticks(10);

        done = 1'b1;
        #30;
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pulse_stretch_multi.md
PULSE_STRETCH_MULTI -- requirements
Module: pulse_stretch_multi

Interface
- REQ-001 Parameter NCH, default 8: number of independent channels.
- REQ-002 Parameter CNT_W, default 8: width of the hold-length count.
- REQ-003 Port clock, input, 1: rising-edge clock for all state.
- REQ-004 Port reset, input, 1: synchronous, active-high reset.
- REQ-005 Port sig_in, input, NCH: raw event inputs, one per channel.
- REQ-006 Port hold_len, input, CNT_W: pulse length in clock cycles, shared by all channels.
- REQ-007 Port retrig, input, 1: mode select. 0 means non-retriggerable; 1 means retriggerable.
- REQ-008 Port enable, input, 1: when 0, new triggers are blocked.
- REQ-009 Port clr_missed, input, 1: single-cycle clear of all missed flags.
- REQ-010 Port sig_out, output, NCH: stretched pulses, registered.
- REQ-011 Port missed, output, NCH: sticky per-channel flags for triggers that were dropped.
- REQ-012 Port busy, output, 1: OR-reduction of sig_out, registered.

Function
- REQ-013 Each channel shall hold its own previous-input register, its own CNT_W-bit down-counter and a 2-state FSM (IDLE, HOLD).
- REQ-014 A channel trigger shall be a rising edge: sig_in[i]=1 at the current edge and prev[i]=0.
- REQ-015 Trigger in IDLE with enable=1: the channel enters HOLD and sig_out[i]=1 from that same clock edge.
- REQ-016 On entering HOLD, the counter shall load the effective length L minus 1, where L = hold_len sampled at the trigger edge.
- REQ-017 When hold_len=0, L shall be taken as 1.
- REQ-018 Each clock in HOLD with counter>0, the counter shall decrement; with counter=0, the channel shall return to IDLE and sig_out[i] shall go to 0.
- REQ-019 Result: sig_out[i] is high for exactly L cycles after a single trigger.
- REQ-020 Trigger in HOLD with retrig=1 and enable=1: the counter shall reload to L-1, with no gap in sig_out[i].
  - This includes a trigger on the final (counter=0) cycle.
- REQ-021 Trigger in HOLD with retrig=0: the trigger shall be ignored and missed[i] set to 1.
  - A trigger on the final cycle is also missed, so the output always drops low for at least 1 cycle between pulses.
- REQ-022 Trigger with enable=0: no state change and missed unaffected; an ongoing HOLD shall run to completion.
- REQ-023 Changes to retrig or hold_len during HOLD shall not alter the current count; they apply only to later triggers or reloads.
- REQ-024 Simultaneous triggers on several channels shall be handled fully independently.
- REQ-025 If clr_missed and a new miss occur in the same cycle, the flag shall end set (set wins).
- REQ-026 A level held high shall produce one trigger only.

Reset
- REQ-027 While reset=1, at every clock:
  - sig_out, missed, busy and all counters shall be 0;
  - all FSMs shall be in IDLE;
  - prev shall be all 0.
- REQ-028 An input that is high at reset release shall trigger once on the first clock after release (if enable=1).
- REQ-029 Reset asserted mid-HOLD shall abort the pulse at the next edge, with no residual count.

Configuration
- REQ-030 Macro PULSE_STRETCH_SYNC_EN: when defined, sig_in shall pass through a per-bit 2-flop synchroniser (reset to 0) before edge detection.
  - This adds exactly 2 cycles of trigger-to-output latency.
- REQ-031 When PULSE_STRETCH_SYNC_EN is undefined, sig_in shall feed edge detection directly, with 0 added latency; all other behaviour is identical.

Verification (macro undefined, NCH=8, CNT_W=8)
- REQ-032 Single pulse: hold_len=20, retrig=0, sig_in[0] high 1 cycle -> sig_out[0] high exactly 20 cycles starting at the sampling edge; busy mirrors it; other channels stay 0.
- REQ-033 Non-retrigger miss: hold_len=10, retrig=0, edges on ch3 at cycles 0 and 5 -> one 10-cycle pulse; missed[3]=1 until clr_missed; clr_missed with a concurrent miss leaves missed[3]=1.
- REQ-034 Retrigger: hold_len=10, retrig=1, edges on ch5 at cycles 0, 5 and 9 (final cycle) -> a continuous pulse of 19 cycles; missed stays 0.
- REQ-035 Boundaries: hold_len=0 gives a 1-cycle pulse; hold_len=255 gives a 255-cycle pulse; a level held high for 300 cycles gives exactly one 255-cycle pulse.
- REQ-036 Enable and reset: enable=0 with edges on all channels -> no outputs and no missed flags; reset asserted at cycle 4 of a 20-cycle pulse -> all outputs 0 at the next edge, and sig_in held high over reset release retriggers once.
- REQ-037 With PULSE_STRETCH_SYNC_EN defined, rerun REQ-032 -> an identical 20-cycle pulse, delayed by 2 cycles.
